// File: rtl/hack_board_pkg.sv
// Shared definitions for the Hack board tops: run-control FSM encoding and button channel indices.
package hack_board_pkg;

    typedef enum logic [1:0] {
        RUNNING = 2'd0,
        PAUSED  = 2'd1,
        STEP    = 2'd2
    } run_state_t;

    localparam int BTN_RUN   = 0;
    localparam int BTN_STEP  = 1;
    localparam int BTN_SPEED = 2;

endpackage

// File: rtl/debounce_bank.sv
// Per-channel button debouncer: 2-flop synchroniser, stability counter, debounced level and rising-edge pulse.
module debounce_bank #(
    parameter int NUM_BTNS      = 3,
    parameter int STABLE_CYCLES = 40
) (
    input  logic                EXTERNAL_CLK,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press
);

    localparam int CW = $clog2(STABLE_CYCLES);

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_ch
        logic [1:0]    sync;
        logic [CW-1:0] cnt;
        logic          lvl;
        logic          prs;

        always_ff @(posedge EXTERNAL_CLK) begin
            if (reset) begin
                sync <= '0;
                cnt  <= '0;
                lvl  <= 1'b0;
                prs  <= 1'b0;
            end else begin
                sync <= {sync[0], btn_raw[gi]};
                if (sync[1] == lvl) begin
                    cnt <= '0;
                    prs <= 1'b0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    // Input has disagreed with the level long enough: accept it.
                    lvl <= sync[1];
                    prs <= sync[1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    prs <= 1'b0;
                end
            end
        end

        assign btn_level[gi] = lvl;
        assign btn_press[gi] = prs;
    end

endmodule

// File: rtl/hack_run_control.sv
// CPU run-control: debounced buttons drive a run/pause/single-step FSM that emits a rate-selectable
// clock enable for the Hack core.
module hack_run_control
    import hack_board_pkg::*;
#(
    parameter int NUM_BTNS      = 3,
    parameter int STABLE_CYCLES = 40,
    parameter int DIV_WIDTH     = 24,
    parameter int START_PAUSED  = 0,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                         EXTERNAL_CLK,
    input  logic                         reset,
    input  logic [NUM_BTNS-1:0]          btn_raw,
    input  logic                         hold_i,
    output logic [NUM_BTNS-1:0]          btn_level,
    output logic [NUM_BTNS-1:0]          btn_press,
    output logic                         cpu_ce,
    output logic                         paused,
    output logic [$clog2(DIV_WIDTH)-1:0] speed_sel,
    output logic [COUNT_WIDTH-1:0]       ce_count
);

    localparam int SW = $clog2(DIV_WIDTH);

    logic [DIV_WIDTH-1:0] divider;
    logic [DIV_WIDTH-1:0] tick_mask;
    logic                 tick;
    run_state_t           state;

    debounce_bank #(
        .NUM_BTNS      (NUM_BTNS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .EXTERNAL_CLK (EXTERNAL_CLK),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .btn_press    (btn_press)
    );

    // Mask of the low speed_sel divider bits; an empty mask (speed 0) ticks every cycle.
    always_comb begin
        tick_mask = '0;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            tick_mask[i] = (i < int'(speed_sel));
        end
        tick = ((divider & tick_mask) == tick_mask);
    end

    always_ff @(posedge EXTERNAL_CLK) begin
        if (reset) begin
            divider   <= '0;
            speed_sel <= '0;
        end else if (btn_press[BTN_SPEED]) begin
            divider   <= '0;
            speed_sel <= (speed_sel == SW'(DIV_WIDTH - 1)) ? '0 : speed_sel + 1'b1;
        end else begin
            divider   <= divider + 1'b1;
        end
    end

    always_ff @(posedge EXTERNAL_CLK) begin
        if (reset) begin
            state    <= (START_PAUSED != 0) ? PAUSED : RUNNING;
            cpu_ce   <= 1'b0;
            ce_count <= '0;
        end else begin
            cpu_ce   <= !hold_i && (((state == RUNNING) && tick) || (state == STEP));
            ce_count <= ce_count + COUNT_WIDTH'(cpu_ce);
            unique case (state)
                RUNNING: if (btn_press[BTN_RUN]) state <= PAUSED;
                PAUSED: begin
                    if (btn_press[BTN_RUN])       state <= RUNNING;
                    else if (btn_press[BTN_STEP]) state <= STEP;
                end
                // A pending step completes before anything else is honoured.
                STEP:    if (!hold_i) state <= PAUSED;
                default: state <= PAUSED;
            endcase
        end
    end

    assign paused = (state != RUNNING);

endmodule

// File: tb/tb_hack_run_control.sv
// Randomised and directed bench for hack_run_control against a sample-history behavioural model.
module tb_hack_run_control;

    localparam int NB  = 3;
    localparam int SC  = 4;
    localparam int DW  = 6;
    localparam int SP  = 0;
    localparam int CW  = 16;
    localparam int SWB = $clog2(DW);
    localparam int MR = 0, MP = 1, MS = 2;

    logic           EXTERNAL_CLK = 1'b0;
    logic           reset  = 1'b1;
    logic           hold_i = 1'b0;
    logic [NB-1:0]  btn_raw = '0;
    logic [NB-1:0]  btn_level, btn_press;
    logic           cpu_ce, paused;
    logic [SWB-1:0] speed_sel;
    logic [CW-1:0]  ce_count;

    int total = 0;
    int bad   = 0;

    hack_run_control #(
        .NUM_BTNS(NB), .STABLE_CYCLES(SC), .DIV_WIDTH(DW), .START_PAUSED(SP), .COUNT_WIDTH(CW)
    ) dut (
        .EXTERNAL_CLK (EXTERNAL_CLK),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .hold_i       (hold_i),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .cpu_ce       (cpu_ce),
        .paused       (paused),
        .speed_sel    (speed_sel),
        .ce_count     (ce_count)
    );

    always #5 EXTERNAL_CLK = ~EXTERNAL_CLK;

    // Reference model: level follows raw once the last SC synchronised samples all disagree with it.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_lvl, m_pr;
    logic          m_ce;
    logic [CW-1:0] m_cnt;
    int            m_mode, m_spd, m_div, per;
    bit            tk, all_diff;

    always @(posedge EXTERNAL_CLK) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i < SC + 2; i++) hist.push_back('0);
            m_lvl = '0; m_pr = '0; m_ce = 1'b0; m_cnt = '0;
            m_mode = (SP != 0) ? MP : MR;
            m_spd = 0; m_div = 0;
        end else begin
            per  = 1 << m_spd;
            tk   = (m_div % per) == per - 1;
            m_cnt = m_cnt + CW'(m_ce);
            m_ce = !hold_i && ((m_mode == MR && tk) || m_mode == MS);
            case (m_mode)
                MR: if (m_pr[0]) m_mode = MP;
                MP: if (m_pr[0]) m_mode = MR; else if (m_pr[1]) m_mode = MS;
                default: if (!hold_i) m_mode = MP;
            endcase
            if (m_pr[2]) begin
                m_div = 0;
                m_spd = (m_spd + 1) % DW;
            end else begin
                m_div = (m_div + 1) % (1 << DW);
            end
            for (int ch = 0; ch < NB; ch++) begin
                all_diff = 1'b1;
                for (int i = 1; i <= SC; i++) if (hist[i][ch] == m_lvl[ch]) all_diff = 1'b0;
                m_pr[ch] = all_diff && !m_lvl[ch];
                if (all_diff) m_lvl[ch] = !m_lvl[ch];
            end
            hist.push_back(btn_raw);
            void'(hist.pop_front());
        end
    end

    function automatic logic [2*NB+SWB+CW+1:0] model_vec();
        return {m_lvl, m_pr, m_ce, logic'(m_mode != MR), SWB'(m_spd), m_cnt};
    endfunction

    task automatic pulse(input int ch, input int hi);
        btn_raw[ch] = 1'b1;
        repeat (hi) @(negedge EXTERNAL_CLK);
        btn_raw[ch] = 1'b0;
        repeat (SC + 4) @(negedge EXTERNAL_CLK);
    endtask

    task automatic test_reset();
        reset = 1'b1; hold_i = 1'b0; btn_raw = '0;
        repeat (3) @(negedge EXTERNAL_CLK);
        total++;
        if ({cpu_ce, ce_count, speed_sel, btn_level, btn_press} !== '0) begin
            bad++; $display("FAIL reset_state: dut=%h exp=0", {cpu_ce, ce_count, speed_sel, btn_level, btn_press});
        end
        total++;
        if (paused !== 1'(SP)) begin bad++; $display("FAIL reset_paused: dut=%b exp=%b", paused, 1'(SP)); end
        reset = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge EXTERNAL_CLK);
            total++;
            if ({btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count} !== model_vec()) begin
                bad++; $display("FAIL run_model: dut=%h exp=%h", {btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count}, model_vec());
            end
            if (k >= 2) begin
                total++;
                if (cpu_ce !== 1'b1) begin bad++; $display("FAIL run_ce k=%0d: dut=%b exp=1", k, cpu_ce); end
            end
        end
        total++;
        if (ce_count !== CW'(10)) begin bad++; $display("FAIL run_count: dut=%0d exp=10", ce_count); end
    endtask

    task automatic test_glitch();
        btn_raw[0] = 1'b1;
        repeat (2) @(negedge EXTERNAL_CLK);
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge EXTERNAL_CLK);
            total++;
            if (btn_press !== '0 || btn_level !== '0 || paused !== 1'b0) begin
                bad++; $display("FAIL glitch: press=%b level=%b paused=%b exp=0", btn_press, btn_level, paused);
            end
        end
    endtask

    task automatic test_pause();
        int np = 0, pk = -1;
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge EXTERNAL_CLK);
            if (btn_press[0]) begin np++; pk = k; end
            total++;
            if ({btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count} !== model_vec()) begin
                bad++; $display("FAIL pause_model: dut=%h exp=%h", {btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count}, model_vec());
            end
        end
        btn_raw[0] = 1'b0;
        total++;
        if (np != 1 || pk != SC + 2) begin bad++; $display("FAIL pause_press: count=%0d at=%0d exp=1 at %0d", np, pk, SC + 2); end
        total++;
        if (paused !== 1'b1 || cpu_ce !== 1'b0) begin bad++; $display("FAIL pause_state: paused=%b ce=%b exp 1/0", paused, cpu_ce); end
        repeat (SC + 4) @(negedge EXTERNAL_CLK);
    endtask

    task automatic test_step();
        int nce = 0;
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge EXTERNAL_CLK);
            if (k == SC + 4) btn_raw[1] = 1'b0;
            nce += int'(cpu_ce);
            total++;
            if ({btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count} !== model_vec()) begin
                bad++; $display("FAIL step_model: dut=%h exp=%h", {btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count}, model_vec());
            end
        end
        total++;
        if (nce != 1 || paused !== 1'b1) begin bad++; $display("FAIL step_once: pulses=%0d paused=%b exp 1/1", nce, paused); end
    endtask

    task automatic test_step_hold();
        int nce = 0;
        hold_i = 1'b1;
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge EXTERNAL_CLK);
            if (k == SC + 4) btn_raw[1] = 1'b0;
            total++;
            if (cpu_ce !== 1'b0) begin bad++; $display("FAIL hold_ce k=%0d: dut=%b exp=0", k, cpu_ce); end
        end
        hold_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge EXTERNAL_CLK);
            nce += int'(cpu_ce);
        end
        total++;
        if (nce != 1 || paused !== 1'b1) begin bad++; $display("FAIL hold_step: pulses=%0d paused=%b exp 1/1", nce, paused); end
    endtask

    task automatic test_both();
        btn_raw[1:0] = 2'b11;
        for (int k = 0; k < SC + 6; k++) begin
            @(negedge EXTERNAL_CLK);
            total++;
            if ({btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count} !== model_vec()) begin
                bad++; $display("FAIL both_model: dut=%h exp=%h", {btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count}, model_vec());
            end
        end
        btn_raw[1:0] = 2'b00;
        repeat (SC + 4) @(negedge EXTERNAL_CLK);
        total++;
        if (paused !== 1'b0) begin bad++; $display("FAIL both_run: paused=%b exp=0", paused); end
    endtask

    task automatic test_speed();
        pulse(2, SC + 4);
        btn_raw[2] = 1'b1;
        for (int k = 0; k < 20 && speed_sel !== SWB'(2); k++) @(negedge EXTERNAL_CLK);
        btn_raw[2] = 1'b0;
        total++;
        if (speed_sel !== SWB'(2)) begin bad++; $display("FAIL speed_timeout: speed=%0d exp=2", speed_sel); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge EXTERNAL_CLK);
            total++;
            if (cpu_ce !== ((k % 4) == 0)) begin bad++; $display("FAIL speed_gap k=%0d: ce=%b exp=%b", k, cpu_ce, (k % 4) == 0); end
        end
        repeat (SC + 4) @(negedge EXTERNAL_CLK);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < DW + 2 && m_spd != DW - 1; i++) pulse(2, SC + 4);
        total++;
        if (speed_sel !== SWB'(DW - 1)) begin bad++; $display("FAIL wrap_top: speed=%0d exp=%0d", speed_sel, DW - 1); end
        pulse(2, SC + 4);
        total++;
        if (speed_sel !== '0) begin bad++; $display("FAIL wrap_zero: speed=%0d exp=0", speed_sel); end
    endtask

    task automatic test_reset_step();
        pulse(0, SC + 4);
        hold_i = 1'b1;
        pulse(1, SC + 4);
        total++;
        if (paused !== 1'b1 || cpu_ce !== 1'b0) begin bad++; $display("FAIL rs_pending: paused=%b ce=%b exp 1/0", paused, cpu_ce); end
        reset = 1'b1;
        @(negedge EXTERNAL_CLK);
        total++;
        if (cpu_ce !== 1'b0 || paused !== 1'(SP) || ce_count !== '0 || speed_sel !== '0) begin
            bad++; $display("FAIL rs_state: ce=%b paused=%b count=%0d speed=%0d exp 0/%0d/0/0", cpu_ce, paused, ce_count, speed_sel, SP);
        end
        reset = 1'b0;
        hold_i = 1'b0;
        repeat (5) @(negedge EXTERNAL_CLK);
        total++;
        if ({btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count} !== model_vec()) begin
            bad++; $display("FAIL rs_model: dut=%h exp=%h", {btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count}, model_vec());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            @(negedge EXTERNAL_CLK);
            total++;
            if ({btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count} !== model_vec()) begin
                bad++; $display("FAIL rand_model k=%0d: dut=%h exp=%h", k, {btn_level, btn_press, cpu_ce, paused, speed_sel, ce_count}, model_vec());
            end
            for (int ch = 0; ch < NB; ch++) if ($urandom_range(0, 9) == 0) btn_raw[ch] = !btn_raw[ch];
            hold_i = ($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_pause();
        test_step();
        test_step_hold();
        test_both();
        test_speed();
        test_wrap();
        test_reset_step();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
